// File: rtl/oc8051_acc_b_dptr_regs_pkg.sv
// Shared SFR addresses, bit-address bases and wr_sfr encodings for the
// ACC / B / DPTR register block.
package oc8051_sfr_pkg;

    localparam logic [7:0] SFR_ACC = 8'hE0;
    localparam logic [7:0] SFR_B   = 8'hF0;
    localparam logic [7:0] SFR_DPL = 8'h82;
    localparam logic [7:0] SFR_DPH = 8'h83;

    localparam logic [4:0] BIT_BASE_ACC = 5'b11100;
    localparam logic [4:0] BIT_BASE_B   = 5'b11110;

    typedef enum logic [1:0] {
        WRS_N    = 2'b00,
        WRS_ACC1 = 2'b01,
        WRS_ACC2 = 2'b10,
        WRS_DPTR = 2'b11
    } wr_sfr_t;

    // True when a plain byte write targets the given SFR address.
    function automatic logic byte_hit(input logic wr, input logic wr_bit,
                                      input logic [7:0] wr_addr,
                                      input logic [7:0] target);
        return wr && !wr_bit && (wr_addr == target);
    endfunction

endpackage

// File: rtl/oc8051_acc_b_dptr_regs_if.sv
// Write-side bus into the ACC/B/DPTR block and the register contents it exposes.
// Writes are single-cycle strobes with no back-pressure: any cycle with wr=1
// or wr_sfr!=00 is taken at the next rising edge, and the result appears one
// cycle later on the read-side signals.
interface oc8051_acc_b_dptr_regs_if;

    logic       wr;
    logic       wr_bit;
    logic [7:0] wr_addr;
    logic [7:0] data_in;
    logic [7:0] data2_in;
    logic       bit_in;
    logic [1:0] wr_sfr;

    logic [7:0] acc;
    logic       p;
    logic [7:0] b_reg;
    logic [7:0] dptr_hi;
    logic [7:0] dptr_lo;

    modport master (
        output wr, wr_bit, wr_addr, data_in, data2_in, bit_in, wr_sfr,
        input  acc, p, b_reg, dptr_hi, dptr_lo
    );

    modport slave (
        input  wr, wr_bit, wr_addr, data_in, data2_in, bit_in, wr_sfr,
        output acc, p, b_reg, dptr_hi, dptr_lo
    );

endinterface

// File: rtl/oc8051_acc_b_dptr_regs_bitaddr_reg.sv
// 8-bit bit-addressable SFR: byte write at BYTE_ADDR, bit write at BIT_BASE,
// plus a higher-priority override load used by the ACC datapath path.
module oc8051_bitaddr_reg
    import oc8051_sfr_pkg::*;
#(
    parameter logic [7:0] RST_VAL   = 8'h00,
    parameter logic [7:0] BYTE_ADDR = SFR_ACC,
    parameter logic [4:0] BIT_BASE  = BIT_BASE_ACC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       wr_bit,
    input  logic [7:0] wr_addr,
    input  logic [7:0] data_in,
    input  logic       bit_in,
    input  logic       ovr_en,
    input  logic [7:0] ovr_data,
    output logic [7:0] q
);

    logic byte_wr;
    logic bit_wr;

    assign byte_wr = byte_hit(wr, wr_bit, wr_addr, BYTE_ADDR);
    assign bit_wr  = wr && wr_bit && (wr_addr[7:3] == BIT_BASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (ovr_en) begin
            q <= ovr_data;
        end else if (byte_wr) begin
            q <= data_in;
        end else if (bit_wr) begin
            q[wr_addr[2:0]] <= bit_in;
        end
    end

endmodule

// File: rtl/oc8051_acc_b_dptr_regs.sv
// ACC, B and DPTR SFR register file with ACC parity output.
// Optional OC8051_DPTR_INC_EN adds a dptr_inc port for 16-bit DPTR increment.
module oc8051_acc_b_dptr_regs
    import oc8051_sfr_pkg::*;
#(
    parameter logic [7:0]  ACC_RST  = 8'h00,
    parameter logic [7:0]  B_RST    = 8'h00,
    parameter logic [15:0] DPTR_RST = 16'h0000
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef OC8051_DPTR_INC_EN
    input  logic                        dptr_inc,
`endif
    oc8051_acc_b_dptr_regs_if.slave     bus
);

    logic [7:0] acc_q;
    logic [7:0] b_q;
    logic [7:0] dph_q;
    logic [7:0] dpl_q;

    logic       acc_ovr_en;
    logic [7:0] acc_ovr_data;
    logic       dptr_sfr_wr;
    logic       dpl_byte_wr;
    logic       dph_byte_wr;

    // Datapath writes (ACC1/ACC2) beat any SFR-bus write to ACC.
    assign acc_ovr_en   = (bus.wr_sfr == WRS_ACC1) || (bus.wr_sfr == WRS_ACC2);
    assign acc_ovr_data = (bus.wr_sfr == WRS_ACC2) ? bus.data2_in : bus.data_in;

    oc8051_bitaddr_reg #(
        .RST_VAL   (ACC_RST),
        .BYTE_ADDR (SFR_ACC),
        .BIT_BASE  (BIT_BASE_ACC)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .wr       (bus.wr),
        .wr_bit   (bus.wr_bit),
        .wr_addr  (bus.wr_addr),
        .data_in  (bus.data_in),
        .bit_in   (bus.bit_in),
        .ovr_en   (acc_ovr_en),
        .ovr_data (acc_ovr_data),
        .q        (acc_q)
    );

    oc8051_bitaddr_reg #(
        .RST_VAL   (B_RST),
        .BYTE_ADDR (SFR_B),
        .BIT_BASE  (BIT_BASE_B)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .wr       (bus.wr),
        .wr_bit   (bus.wr_bit),
        .wr_addr  (bus.wr_addr),
        .data_in  (bus.data_in),
        .bit_in   (bus.bit_in),
        .ovr_en   (1'b0),
        .ovr_data (8'h00),
        .q        (b_q)
    );

    assign dptr_sfr_wr = (bus.wr_sfr == WRS_DPTR);
    assign dpl_byte_wr = byte_hit(bus.wr, bus.wr_bit, bus.wr_addr, SFR_DPL);
    assign dph_byte_wr = byte_hit(bus.wr, bus.wr_bit, bus.wr_addr, SFR_DPH);

    // DPTR is byte-only; the datapath load takes both halves at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            {dph_q, dpl_q} <= DPTR_RST;
        end else if (dptr_sfr_wr) begin
            dph_q <= bus.data2_in;
            dpl_q <= bus.data_in;
        end else if (dpl_byte_wr) begin
            dpl_q <= bus.data_in;
        end else if (dph_byte_wr) begin
            dph_q <= bus.data_in;
`ifdef OC8051_DPTR_INC_EN
        end else if (dptr_inc) begin
            {dph_q, dpl_q} <= {dph_q, dpl_q} + 16'd1;
`endif
        end
    end

    assign bus.acc     = acc_q;
    assign bus.p       = ^acc_q;
    assign bus.b_reg   = b_q;
    assign bus.dptr_hi = dph_q;
    assign bus.dptr_lo = dpl_q;

endmodule

// File: tb/tb_oc8051_acc_b_dptr_regs.sv
// Self-checking bench for oc8051_acc_b_dptr_regs: directed cases followed by
// random writes compared against a register-level reference model.
module tb_oc8051_acc_b_dptr_regs;

    logic clk;
    logic rst;
    logic dptr_inc;

    oc8051_acc_b_dptr_regs_if bus ();

    oc8051_acc_b_dptr_regs dut (
        .clk      (clk),
`ifdef OC8051_DPTR_INC_EN
        .dptr_inc (dptr_inc),
`endif
        .rst      (rst),
        .bus      (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned m_acc;
    int unsigned m_b;
    int unsigned m_dptr;

    int n_cmp;
    int n_err;

    task automatic model_edge();
        int unsigned a;
        a = bus.wr_addr;
        if (rst) begin
            m_acc  = 0;
            m_b    = 0;
            m_dptr = 0;
            return;
        end
        // Accumulator
        if (bus.wr_sfr == 2'd1) m_acc = bus.data_in;
        else if (bus.wr_sfr == 2'd2) m_acc = bus.data2_in;
        else if (bus.wr && !bus.wr_bit && a == 'hE0) m_acc = bus.data_in;
        else if (bus.wr && bus.wr_bit && a >= 'hE0 && a <= 'hE7)
            m_acc = bus.bit_in ? (m_acc | (1 << (a - 'hE0))) : (m_acc & ~(1 << (a - 'hE0)) & 'hFF);
        // B register
        if (bus.wr && !bus.wr_bit && a == 'hF0) m_b = bus.data_in;
        else if (bus.wr && bus.wr_bit && a >= 'hF0 && a <= 'hF7)
            m_b = bus.bit_in ? (m_b | (1 << (a - 'hF0))) : (m_b & ~(1 << (a - 'hF0)) & 'hFF);
        // Data pointer as a single 16-bit number
        if (bus.wr_sfr == 2'd3) m_dptr = bus.data2_in * 256 + bus.data_in;
        else if (bus.wr && !bus.wr_bit && a == 'h82) m_dptr = (m_dptr / 256) * 256 + bus.data_in;
        else if (bus.wr && !bus.wr_bit && a == 'h83) m_dptr = bus.data_in * 256 + (m_dptr % 256);
`ifdef OC8051_DPTR_INC_EN
        else if (dptr_inc) m_dptr = (m_dptr + 1) % 65536;
`endif
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".acc"},     {8'h00, bus.acc},     m_acc[15:0]);
        check({tag, ".p"},       {15'h0, bus.p},       16'($countones(m_acc) % 2));
        check({tag, ".b_reg"},   {8'h00, bus.b_reg},   m_b[15:0]);
        check({tag, ".dptr_hi"}, {8'h00, bus.dptr_hi}, 16'(m_dptr / 256));
        check({tag, ".dptr_lo"}, {8'h00, bus.dptr_lo}, 16'(m_dptr % 256));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic w, input logic wb, input logic [7:0] addr,
                         input logic [7:0] d, input logic [7:0] d2, input logic bi,
                         input logic [1:0] sfr, input logic inc);
        bus.wr       = w;
        bus.wr_bit   = wb;
        bus.wr_addr  = addr;
        bus.data_in  = d;
        bus.data2_in = d2;
        bus.bit_in   = bi;
        bus.wr_sfr   = sfr;
        dptr_inc     = inc;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0);
    endtask

    // Directed expectations that do not rely on the model.
    task automatic expect_regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] dp);
        check({tag, ".acc_k"},  {8'h00, bus.acc},   {8'h00, a});
        check({tag, ".b_k"},    {8'h00, bus.b_reg}, {8'h00, b});
        check({tag, ".dptr_k"}, {bus.dptr_hi, bus.dptr_lo}, dp);
    endtask

    logic [7:0] addr_pool [20];

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_acc = 0; m_b = 0; m_dptr = 0;
        rst = 1'b1;
        idle();
        bus.data_in = 8'hFF; bus.wr = 1'b1; bus.wr_addr = 8'hE0;  // reset must win
        step("reset");
        check("reset.p_k", {15'h0, bus.p}, 16'h0000);
        expect_regs("reset", 8'h00, 8'h00, 16'h0000);
        rst = 1'b0;

        drive(1, 0, 8'hE0, 8'h07, 8'h00, 0, 2'b00, 0); step("acc_byte");
        check("acc_byte.p_k", {15'h0, bus.p}, 16'h0001);
        drive(1, 0, 8'hF0, 8'hA5, 8'h00, 0, 2'b00, 0); step("b_byte");
        expect_regs("b_byte", 8'h07, 8'hA5, 16'h0000);
        drive(1, 1, 8'hE7, 8'h00, 8'h00, 1, 2'b00, 0); step("acc_bit7");
        expect_regs("acc_bit7", 8'h87, 8'hA5, 16'h0000);
        check("acc_bit7.p_k", {15'h0, bus.p}, 16'h0000);

        drive(1, 0, 8'hE0, 8'h11, 8'h3C, 0, 2'b10, 0); step("acc2_over_byte");
        expect_regs("acc2_over_byte", 8'h3C, 8'hA5, 16'h0000);
        drive(0, 0, 8'h00, 8'h55, 8'h00, 0, 2'b01, 0); step("acc1");
        expect_regs("acc1", 8'h55, 8'hA5, 16'h0000);
        drive(1, 0, 8'hF0, 8'h66, 8'h99, 0, 2'b10, 0); step("acc2_with_b");
        expect_regs("acc2_with_b", 8'h99, 8'h66, 16'h0000);
        drive(1, 1, 8'hF3, 8'h00, 8'h00, 0, 2'b00, 0); step("b_bit3_clr");
        expect_regs("b_bit3_clr", 8'h99, 8'h66, 16'h0000);
        drive(1, 1, 8'hF0, 8'h00, 8'h00, 1, 2'b00, 0); step("b_bit0_set");
        expect_regs("b_bit0_set", 8'h99, 8'h67, 16'h0000);

        drive(1, 0, 8'h82, 8'h34, 8'h12, 0, 2'b11, 0); step("dptr_sfr");
        expect_regs("dptr_sfr", 8'h99, 8'h67, 16'h1234);
        drive(1, 0, 8'h83, 8'hAB, 8'h00, 0, 2'b00, 0); step("dph_byte");
        expect_regs("dph_byte", 8'h99, 8'h67, 16'hAB34);
        drive(1, 1, 8'h82, 8'h00, 8'h00, 1, 2'b00, 0); step("dpl_bit_ignored");
        expect_regs("dpl_bit_ignored", 8'h99, 8'h67, 16'hAB34);
        drive(1, 0, 8'h82, 8'hC3, 8'h00, 0, 2'b00, 0); step("dpl_byte");
        expect_regs("dpl_byte", 8'h99, 8'h67, 16'hABC3);

        drive(1, 0, 8'hE1, 8'hEE, 8'hEE, 1, 2'b00, 0); step("miss_e1");
        drive(1, 0, 8'hF1, 8'hEE, 8'hEE, 1, 2'b00, 0); step("miss_f1");
        drive(1, 0, 8'h81, 8'hEE, 8'hEE, 1, 2'b00, 0); step("miss_81");
        idle(); bus.data_in = 8'hEE; bus.wr_addr = 8'hE0; step("wr_low");
        expect_regs("misses", 8'h99, 8'h67, 16'hABC3);

`ifdef OC8051_DPTR_INC_EN
        drive(0, 0, 8'h00, 8'hFF, 8'h00, 0, 2'b11, 0); step("inc_setup1");
        drive(0, 0, 8'h00, 8'h00, 8'h00, 0, 2'b00, 1); step("inc_carry");
        expect_regs("inc_carry", 8'h99, 8'h67, 16'h0100);
        drive(0, 0, 8'h00, 8'hFF, 8'hFF, 0, 2'b11, 0); step("inc_setup2");
        drive(0, 0, 8'h00, 8'h00, 8'h00, 0, 2'b00, 1); step("inc_wrap");
        expect_regs("inc_wrap", 8'h99, 8'h67, 16'h0000);
        drive(0, 0, 8'h00, 8'h78, 8'h56, 0, 2'b11, 1); step("inc_vs_sfr");
        expect_regs("inc_vs_sfr", 8'h99, 8'h67, 16'h5678);
        drive(1, 0, 8'h83, 8'h9A, 8'h00, 0, 2'b00, 1); step("inc_vs_dph");
        expect_regs("inc_vs_dph", 8'h99, 8'h67, 16'h9A78);
`endif

        // Random phase: addresses biased toward the decoded ones and near misses.
        addr_pool = '{8'hE0, 8'hE1, 8'hE2, 8'hE5, 8'hE7, 8'hE8, 8'hF0, 8'hF1, 8'hF4, 8'hF7,
                      8'hF8, 8'h82, 8'h83, 8'h81, 8'h84, 8'hD0, 8'h60, 8'h70, 8'h02, 8'h03};
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 19)];
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), ra, 8'($urandom), 8'($urandom),
                  1'($urandom), ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00, 1'($urandom));
            rst = ($urandom_range(0, 99) == 0);
            step("rand");
        end
        rst = 1'b0;
        idle();
        step("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
